// File: rtl/eth_host_cmd_slave.sv
// Device-side responder for the Ethernet host command port: turns host commands into data/program
// memory strobes, serves data-memory readback, and runs the IDLE/RUN/DONE start handshake.
module eth_host_cmd_slave #(
  parameter int          NUM_PROC  = 7,
  parameter int          AW        = 11,
  parameter int          DW        = 60,
  parameter int          PW        = 32,
  parameter int          RD_LAT    = 2,
  parameter logic [7:0]  CMD_WR    = 8'd1,
  parameter logic [7:0]  CMD_RD    = 8'd2,
  parameter logic [7:0]  CMD_START = 8'd65
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                interrupt_eth,
  input  logic [7:0]          instruction_eth,
  input  logic [7:0]          operand_eth,
  input  logic [AW-1:0]       address_eth,
  input  logic                web_eth,
  input  logic                wep_eth,
  input  logic [DW-1:0]       dinb_eth,
  output logic [DW-1:0]       doutb_eth,
  output logic [NUM_PROC-1:0] mem_we,
  output logic                mem_re,
  output logic [2:0]          mem_proc,
  output logic [4:0]          mem_sel,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_din,
  input  logic [DW-1:0]       mem_rdata,
  output logic                prog_we,
  output logic [AW-1:0]       prog_addr,
  output logic [PW-1:0]       prog_din,
  output logic                core_start,
  input  logic                core_done,
  output logic                done_comp,
  output logic                cmd_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [NUM_PROC-1:0] mem_we_q, mem_we_d;
  logic                mem_re_q, mem_re_d;
  logic [2:0]          mem_proc_q, mem_proc_d;
  logic [4:0]          mem_sel_q, mem_sel_d;
  logic [AW-1:0]       mem_addr_q, mem_addr_d;
  logic [DW-1:0]       mem_din_q, mem_din_d;
  logic                prog_we_q, prog_we_d;
  logic [AW-1:0]       prog_addr_q, prog_addr_d;
  logic [PW-1:0]       prog_din_q, prog_din_d;
  logic                core_start_q, core_start_d;
  logic                done_comp_q, done_comp_d;
  logic                cmd_err_q, cmd_err_d;
  logic [DW-1:0]       doutb_q, doutb_d;
  logic [RD_LAT-1:0]   rd_pipe_q, rd_pipe_d;

  logic [2:0] proc_sel;
  logic       wr_req, rd_req, start_req, proc_ok;

  assign proc_sel  = operand_eth[7:5];
  assign wr_req    = interrupt_eth && (instruction_eth == CMD_WR) && web_eth;
  assign rd_req    = interrupt_eth && (instruction_eth == CMD_RD);
  assign start_req = !interrupt_eth && (instruction_eth == CMD_START);
  assign proc_ok   = ({29'd0, proc_sel} < 32'(NUM_PROC));

  always_comb begin
    state_d      = state_q;
    mem_we_d     = '0;
    mem_re_d     = 1'b0;
    mem_proc_d   = mem_proc_q;
    mem_sel_d    = mem_sel_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    prog_we_d    = 1'b0;
    prog_addr_d  = prog_addr_q;
    prog_din_d   = prog_din_q;
    core_start_d = 1'b0;
    cmd_err_d    = cmd_err_q;

    // Read valid marches alongside the memory latency; capture when it falls off the end.
    rd_pipe_d[0] = mem_re_q;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_pipe_d[i] = rd_pipe_q[i-1];
    end
    doutb_d = rd_pipe_q[RD_LAT-1] ? mem_rdata : doutb_q;

    case (state_q)
      IDLE: begin
        if (wr_req) begin
          if (proc_ok) begin
            mem_we_d   = {{(NUM_PROC-1){1'b0}}, 1'b1} << proc_sel;
            mem_proc_d = proc_sel;
            mem_sel_d  = operand_eth[4:0];
            mem_addr_d = address_eth;
            mem_din_d  = dinb_eth;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        if (rd_req) begin
          mem_re_d   = 1'b1;
          mem_proc_d = proc_sel;
          mem_sel_d  = operand_eth[4:0];
          mem_addr_d = address_eth;
        end
        if (wep_eth) begin
          prog_we_d   = 1'b1;
          prog_addr_d = address_eth;
          prog_din_d  = dinb_eth[PW-1:0];
        end
        if (start_req) begin
          core_start_d = 1'b1;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (wr_req || rd_req || wep_eth) cmd_err_d = 1'b1;
        if (core_done) state_d = DONE;
      end
      DONE: begin
        if (instruction_eth != CMD_START) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    done_comp_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_we_q     <= '0;
      mem_re_q     <= 1'b0;
      mem_proc_q   <= '0;
      mem_sel_q    <= '0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      prog_we_q    <= 1'b0;
      prog_addr_q  <= '0;
      prog_din_q   <= '0;
      core_start_q <= 1'b0;
      done_comp_q  <= 1'b0;
      cmd_err_q    <= 1'b0;
      doutb_q      <= '0;
      rd_pipe_q    <= '0;
    end else begin
      state_q      <= state_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      mem_proc_q   <= mem_proc_d;
      mem_sel_q    <= mem_sel_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      prog_we_q    <= prog_we_d;
      prog_addr_q  <= prog_addr_d;
      prog_din_q   <= prog_din_d;
      core_start_q <= core_start_d;
      done_comp_q  <= done_comp_d;
      cmd_err_q    <= cmd_err_d;
      doutb_q      <= doutb_d;
      rd_pipe_q    <= rd_pipe_d;
    end
  end

  assign doutb_eth  = doutb_q;
  assign mem_we     = mem_we_q;
  assign mem_re     = mem_re_q;
  assign mem_proc   = mem_proc_q;
  assign mem_sel    = mem_sel_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign prog_we    = prog_we_q;
  assign prog_addr  = prog_addr_q;
  assign prog_din   = prog_din_q;
  assign core_start = core_start_q;
  assign done_comp  = done_comp_q;
  assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_eth_host_cmd_slave.sv
// Directed plus randomized check of eth_host_cmd_slave against a cycle-level behavioural model.
module tb_eth_host_cmd_slave;
  localparam int NUM_PROC = 7;
  localparam int AW       = 11;
  localparam int DW       = 60;
  localparam int PW       = 32;
  localparam int RD_LAT   = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                interrupt_eth;
  logic [7:0]          instruction_eth;
  logic [7:0]          operand_eth;
  logic [AW-1:0]       address_eth;
  logic                web_eth;
  logic                wep_eth;
  logic [DW-1:0]       dinb_eth;
  logic [DW-1:0]       doutb_eth;
  logic [NUM_PROC-1:0] mem_we;
  logic                mem_re;
  logic [2:0]          mem_proc;
  logic [4:0]          mem_sel;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_din;
  logic [DW-1:0]       mem_rdata;
  logic                prog_we;
  logic [AW-1:0]       prog_addr;
  logic [PW-1:0]       prog_din;
  logic                core_start;
  logic                core_done;
  logic                done_comp;
  logic                cmd_err;

  eth_host_cmd_slave dut (
    .clk(clk), .rst(rst), .interrupt_eth(interrupt_eth), .instruction_eth(instruction_eth),
    .operand_eth(operand_eth), .address_eth(address_eth), .web_eth(web_eth), .wep_eth(wep_eth),
    .dinb_eth(dinb_eth), .doutb_eth(doutb_eth), .mem_we(mem_we), .mem_re(mem_re),
    .mem_proc(mem_proc), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_rdata(mem_rdata), .prog_we(prog_we), .prog_addr(prog_addr), .prog_din(prog_din),
    .core_start(core_start), .core_done(core_done), .done_comp(done_comp), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // Memory model: data for address A is addr+100, valid RD_LAT cycles after mem_re, junk otherwise.
  logic [AW:0] rdp [RD_LAT];
  initial for (int k = 0; k < RD_LAT; k++) rdp[k] = '0;
  always @(posedge clk) begin
    rdp[0] <= {mem_re, mem_addr};
    for (int k = 1; k < RD_LAT; k++) rdp[k] <= rdp[k-1];
  end
  assign mem_rdata = rdp[RD_LAT-1][AW] ? (DW'(rdp[RD_LAT-1][AW-1:0]) + DW'(100)) : {DW{1'b1}};

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_start  = 0;

  // Reference model state: running / finished flags, sticky error, expected readback.
  bit            m_run, m_fin, m_err;
  logic [DW-1:0] m_dout;
  typedef struct { int due; logic [DW-1:0] val; } rd_t;
  rd_t rdq[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic intr, input logic [7:0] instr, input logic [7:0] op,
                       input logic [AW-1:0] a, input logic we, input logic pe,
                       input logic [DW-1:0] d, input logic cd);
    interrupt_eth   = intr;
    instruction_eth = instr;
    operand_eth     = op;
    address_eth     = a;
    web_eth         = we;
    wep_eth         = pe;
    dinb_eth        = d;
    core_done       = cd;
  endtask

  task automatic do_reset();
    drive(1'b0, 8'd0, 8'd0, '0, 1'b0, 1'b0, '0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_run = 0; m_fin = 0; m_err = 0; m_dout = '0;
    rdq.delete();
    chk("rst_mem_we", 64'(mem_we), 64'h0);
    chk("rst_mem_re", 64'(mem_re), 64'h0);
    chk("rst_prog_we", 64'(prog_we), 64'h0);
    chk("rst_core_start", 64'(core_start), 64'h0);
    chk("rst_done_comp", 64'(done_comp), 64'h0);
    chk("rst_cmd_err", 64'(cmd_err), 64'h0);
    chk("rst_doutb", 64'(doutb_eth), 64'h0);
    chk("rst_mem_addr", 64'(mem_addr), 64'h0);
  endtask

  // One clock of stimulus (already driven) followed by a full comparison against the model.
  task automatic step();
    logic [NUM_PROC-1:0] e_we;
    logic                e_re, e_pwe, e_start, wr, rd;
    logic [2:0]          ps;
    logic [4:0]          sel;
    logic [AW-1:0]       a;
    logic [DW-1:0]       d;
    e_we = '0; e_re = 1'b0; e_pwe = 1'b0; e_start = 1'b0;
    ps  = operand_eth[7:5];
    sel = operand_eth[4:0];
    a   = address_eth;
    d   = dinb_eth;
    wr  = interrupt_eth && (instruction_eth == 8'd1) && web_eth;
    rd  = interrupt_eth && (instruction_eth == 8'd2);
    if (m_run) begin
      if (wr || rd || wep_eth) m_err = 1;
      if (core_done) begin m_run = 0; m_fin = 1; end
    end else if (m_fin) begin
      if (instruction_eth != 8'd65) m_fin = 0;
    end else begin
      if (wr) begin
        if (int'(ps) < NUM_PROC) e_we[ps] = 1'b1;
        else m_err = 1;
      end
      if (rd) e_re = 1'b1;
      if (wep_eth) e_pwe = 1'b1;
      if (!interrupt_eth && instruction_eth == 8'd65) begin e_start = 1'b1; m_run = 1; end
    end
    tick();
    while (rdq.size() > 0 && rdq[0].due == cyc) begin
      m_dout = rdq[0].val;
      void'(rdq.pop_front());
    end
    if (e_re) rdq.push_back('{due: cyc + RD_LAT + 1, val: DW'(a) + DW'(100)});
    if (core_start) n_start++;
    chk("mem_we", 64'(mem_we), 64'(e_we));
    chk("mem_re", 64'(mem_re), 64'(e_re));
    chk("prog_we", 64'(prog_we), 64'(e_pwe));
    chk("core_start", 64'(core_start), 64'(e_start));
    chk("done_comp", 64'(done_comp), 64'(m_fin));
    chk("cmd_err", 64'(cmd_err), 64'(m_err));
    chk("doutb", 64'(doutb_eth), 64'(m_dout));
    if (e_we != '0 || e_re) begin
      chk("mem_proc", 64'(mem_proc), 64'(ps));
      chk("mem_sel", 64'(mem_sel), 64'(sel));
      chk("mem_addr", 64'(mem_addr), 64'(a));
    end
    if (e_we != '0) chk("mem_din", 64'(mem_din), 64'(d));
    if (e_pwe) begin
      chk("prog_addr", 64'(prog_addr), 64'(a));
      chk("prog_din", 64'(prog_din), 64'(d[PW-1:0]));
    end
  endtask

  initial begin
    logic [31:0]   pdat [5];
    logic [7:0]    instr;
    logic [DW-1:0] din;
    pdat = '{32'h0, 32'h0, 32'h05040014, 32'h0, 32'hFF};
    rst = 1'b1;
    do_reset();

    // Data write proc0 mem4 addr0
    din = {30'd87381051, 30'd1007649774};
    drive(1'b1, 8'd1, 8'h04, '0, 1'b1, 1'b0, din, 1'b0);
    step();
    chk("t1_we", 64'(mem_we), 64'h01);
    chk("t1_sel", 64'(mem_sel), 64'd4);
    chk("t1_din", 64'(mem_din), 64'(din));
    chk("t1_prog_we", 64'(prog_we), 64'h0);
    drive(1'b1, 8'd0, 8'h00, '0, 1'b0, 1'b0, '0, 1'b0);
    step();

    // proc6 accepted, proc7 dropped with error
    drive(1'b1, 8'd1, 8'hC4, 11'd9, 1'b1, 1'b0, DW'(60'h123456789ABCDEF), 1'b0);
    step();
    chk("t2_we6", 64'(mem_we), 64'h40);
    drive(1'b1, 8'd1, 8'hE4, 11'd9, 1'b1, 1'b0, DW'(60'h0FEDCBA987654321), 1'b0);
    step();
    chk("t2_we7", 64'(mem_we), 64'h0);
    chk("t2_err", 64'(cmd_err), 64'h1);

    // Program writes, upper dinb bits random to exercise truncation
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 8'd0, 8'd0, AW'(i), 1'b0, 1'b1, DW'({$urandom(), pdat[i]}), 1'b0);
      step();
      chk("t3_pdin", 64'(prog_din), 64'(pdat[i]));
    end

    // Start handshake
    do_reset();
    n_start = 0;
    drive(1'b0, 8'd65, 8'd0, '0, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 50; i++) step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_done_held", 64'(done_comp), 64'h1);
    end
    instruction_eth = 8'd1;
    step();
    chk("t4_done_clr", 64'(done_comp), 64'h0);
    for (int i = 0; i < 3; i++) step();
    chk("t4_one_start", 64'(n_start), 64'd1);

    // Writes during RUN, then reset mid-RUN
    chk("t5_err_pre", 64'(cmd_err), 64'h0);
    drive(1'b0, 8'd65, 8'd0, '0, 1'b0, 1'b0, '0, 1'b0);
    step();
    drive(1'b1, 8'd1, 8'h00, 11'd5, 1'b1, 1'b0, DW'(60'hABC), 1'b0);
    step();
    chk("t5_no_we", 64'(mem_we), 64'h0);
    chk("t5_err", 64'(cmd_err), 64'h1);
    step();
    do_reset();
    n_start = 0;
    for (int i = 0; i < 3; i++) step();
    chk("t5_no_restart", 64'(n_start), 64'd0);

    // Back-to-back reads
    drive(1'b1, 8'd2, 8'h00, 11'd0, 1'b0, 1'b0, '0, 1'b0);
    step();
    address_eth = 11'd1;
    step();
    drive(1'b1, 8'd0, 8'h00, '0, 1'b0, 1'b0, '0, 1'b0);
    step();
    step();
    chk("t6_rd0", 64'(doutb_eth), 64'd100);
    step();
    chk("t6_rd1", 64'(doutb_eth), 64'd101);
    step();
    chk("t6_hold", 64'(doutb_eth), 64'd101);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: instr = 8'd1;
        4, 5, 6:    instr = 8'd2;
        7:          instr = 8'd65;
        8:          instr = 8'd0;
        default:    instr = 8'($urandom());
      endcase
      din = DW'({$urandom(), $urandom()});
      drive(1'($urandom_range(0, 1)), instr, 8'($urandom()), AW'($urandom()),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), din,
            ($urandom_range(0, 7) == 0));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
